// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with two-flop synchronizer and framing check
module uart_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state, state_n;
    logic                 sync1, rx_s;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n;

    // Synchronizer resets low so a line stuck low through reset parks in WAIT_IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            rx_s        <= 1'b0;
            state       <= WAIT_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            sync1       <= rx;
            rx_s        <= sync1;
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= idx_n;
            shift       <= shift_n;
            rx_data     <= data_n;
            rx_valid    <= valid_n;
            frame_error <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (rx_s) state_n = IDLE;
            end
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Re-check at mid start bit; a high line here is a glitch
                if (cnt == HALF_CNT) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    shift_n[bit_idx] = rx_s;
                    cnt_n            = '0;
                    idx_n            = bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_BIT) state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start be caught
                if (cnt == LAST_CNT) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    assign rx_busy = (state == START) || (state == DATA) || (state == STOP);

endmodule
